cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
- Shares one 32-bit magnitude-compare datapath between NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester presents an operand pair with a valid/ready handshake. The block captures the pair, runs the compare over CMP_LAT cycles, and returns a 2-bit result code tagged with the requester ID.
- Sits between ALU-using clients (sort/min-max/branch-resolve engines) and the compare core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width
- CMP_LAT, 1, compare execution cycles (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  $clog2(NUM_REQ)  requester index that owns the result
- rsp_code  out  2  {c1,c0}: 2'b11 a==b, 2'b10 a<b, 2'b01 a>b; never 2'b00 while rsp_valid=1

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_code=2'b00, req_ready=0, latency counter=0, captured operands=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit is grant g.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - At the clock edge: capture req_a[g], req_b[g] and g; set rr_ptr=(g+1) mod NUM_REQ; load counter=CMP_LAT-1; go to EXEC.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - req_ready=0.
  - Decrement the counter each cycle.
  - When the counter is 0: register the compare result into rsp_code, set rsp_valid=1, go to RESP.
  - Latency: handshake cycle to first rsp_valid cycle = CMP_LAT+1 edges.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_code stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge: rsp_valid=0, go to IDLE.
  - No response skid buffer. With rsp_ready tied high, the minimum issue interval is CMP_LAT+2 cycles.
- Compare: unsigned by default. Equality takes precedence over lt/gt. The result uses only the captured operands, so requester inputs may change after the handshake.
- Fairness: a requester that holds valid is granted within NUM_REQ grants.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - Dropping valid before ready is legal and withdraws the request; no state changes.
- rsp_ready asserted outside RESP is ignored.
- rst asserted in EXEC or RESP: the in-flight request is discarded with no response. The block is in IDLE with reset values on the next cycle.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: CMP_ARBITER_SIGNED_EN.
- Defined:
  - Adds input req_signed [NUM_REQ], captured with the operands at grant.
  - A captured 1 selects a two's-complement compare; 0 selects unsigned.
- Undefined:
  - The port is absent and all compares are unsigned.
- The rsp_code encoding is the same in both builds.

Decomposition:
- Shared package cmp_pkg holds:
  - CMP_EQ=2'b11, CMP_LT=2'b10, CMP_GT=2'b01
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- Sub-module cmp_core: combinational compare of two WIDTH operands plus a signed select, producing the 2-bit code.
- cmp_arbiter: FSM, round-robin pointer, latency counter, operand/result registers.

Test Plan:
- Reset, then req_valid=4'b0001 with a=b=32'h1234_5678 -> req_ready=4'b0001 for 1 cycle. With CMP_LAT=1, rsp_valid at edge 2 with rsp_id=0, rsp_code=2'b11.
- req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0. Requester 1 with a=5, b=9 -> code 2'b10. Requester 2 with a=9, b=5 -> code 2'b01.
- a=32'h0000_0000, b=32'hFFFF_FFFF, unsigned -> 2'b10. With CMP_ARBITER_SIGNED_EN and req_signed=1 -> 2'b01.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_code stable; req_ready stays 0 even with requests pending. Releasing rsp_ready returns the block to IDLE.
- rst pulsed during EXEC (CMP_LAT=3) -> no rsp_valid; rr_ptr=0. Then req_valid=4'b1010 -> requester 1 granted first.
- Requester 3 drops valid before grant while requester 1 is being serviced -> requester 3 never receives req_ready; no spurious response.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the compare arbiter: result codes, FSM states, counter width.
package cmp_pkg;

    localparam logic [1:0] CMP_EQ = 2'b11;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_GT = 2'b01;

    // Holds CMP_LAT-1 for CMP_LAT up to 4.
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester/response bundle for cmp_arbiter; req_signed exists only when
// CMP_ARBITER_SIGNED_EN is defined.
interface cmp_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
`ifdef CMP_ARBITER_SIGNED_EN
    logic [NUM_REQ-1:0]       req_signed;
`endif
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [1:0]               rsp_code;

`ifdef CMP_ARBITER_SIGNED_EN
    modport master (
        output req_valid, req_a, req_b, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_code
    );
    modport slave (
        input  req_valid, req_a, req_b, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_code
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_code
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_code
    );
`endif

endinterface

// File: rtl/cmp_core.sv
// Combinational magnitude compare; equality wins over lt/gt, signed_sel picks
// two's-complement ordering.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_sel,
    output logic [1:0]       code_c
);

    logic lt_c;

    assign lt_c = signed_sel ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        code_c = CMP_GT;
        if (a == b) begin
            code_c = CMP_EQ;
        end else if (lt_c) begin
            code_c = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one compare datapath among NUM_REQ requesters.
// Optional CMP_ARBITER_SIGNED_EN adds per-requester signed-compare select.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CMP_LAT = 1
) (
    input logic        clk,
    input logic        rst,
    cmp_arbiter_if.slave bus
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_idx_c;
    logic               grant_vld_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               grant_fire_c;
    logic               done_c;
    logic               rsp_fire_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sgn_q;
    logic [1:0]         code_c;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [1:0]         rsp_code_q;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!grant_vld_c && bus.req_valid[ID_W'(j)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake strobes; reset masks any same-cycle grant.
    always_comb begin
        state_d      = state_q;
        req_ready_c  = '0;
        grant_fire_c = 1'b0;
        done_c       = 1'b0;
        rsp_fire_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld_c && !rst) begin
                    req_ready_c[grant_idx_c] = 1'b1;
                    grant_fire_c             = 1'b1;
                    state_d                  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_fire_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, pointer advance, latency count and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_code_q  <= 2'b00;
        end else begin
            if (grant_fire_c) begin
                a_q      <= bus.req_a[32'(grant_idx_c)*WIDTH +: WIDTH];
                b_q      <= bus.req_b[32'(grant_idx_c)*WIDTH +: WIDTH];
                rsp_id_q <= grant_idx_c;
                rr_ptr_q <= (grant_idx_c == ID_W'(NUM_REQ-1)) ? '0 : grant_idx_c + 1'b1;
                cnt_q    <= CNT_W'(CMP_LAT-1);
            end
            if (state_q == EXEC && !done_c) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done_c) begin
                rsp_code_q  <= code_c;
                rsp_valid_q <= 1'b1;
            end
            if (rsp_fire_c) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef CMP_ARBITER_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q <= 1'b0;
        end else if (grant_fire_c) begin
            sgn_q <= bus.req_signed[grant_idx_c];
        end
    end
`else
    assign sgn_q = 1'b0;
`endif

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a          (a_q),
        .b          (b_q),
        .signed_sel (sgn_q),
        .code_c     (code_c)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: one instance at CMP_LAT=1, one at CMP_LAT=3.
module tb_cmp_arbiter;

    logic clk;
    logic rst;
    logic rst3;
    int   tests;
    int   fails;
    logic [1:0] codes [4];

    cmp_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus  ();
    cmp_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus3 ();

    cmp_arbiter #(.NUM_REQ(4), .WIDTH(32), .CMP_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cmp_arbiter #(.NUM_REQ(4), .WIDTH(32), .CMP_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic set_ops3(input int i, input logic [31:0] a, input logic [31:0] b);
        bus3.req_a[i*32 +: 32] = a;
        bus3.req_b[i*32 +: 32] = b;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        codes[0] = 2'b11;
        codes[1] = 2'b10;
        codes[2] = 2'b01;
        codes[3] = 2'b10;
        rst  = 1'b1;
        rst3 = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        bus3.req_valid = '0;
        bus3.req_a     = '0;
        bus3.req_b     = '0;
        bus3.rsp_ready = 1'b0;
`ifdef CMP_ARBITER_SIGNED_EN
        bus.req_signed  = '0;
        bus3.req_signed = '0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_code",  32'(bus.rsp_code),  32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst  = 1'b0;
        rst3 = 1'b0;

        // Single request, equal operands
        set_ops(0, 32'h1234_5678, 32'h1234_5678);
        bus.req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        check("t1_ready_exec", 32'(bus.req_ready), 32'h0);
        check("t1_no_valid_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("t1_rsp_code",  32'(bus.rsp_code),  32'h3);
        bus.rsp_ready = 1'b1;
        tick();
        check("t1_rsp_drop", 32'(bus.rsp_valid), 32'd0);

        // Round robin over all requesters, rsp_ready held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(0, 32'd1, 32'd1);
        set_ops(1, 32'd5, 32'd9);
        set_ops(2, 32'd9, 32'd5);
        set_ops(3, 32'h0000_0000, 32'hFFFF_FFFF);
        bus.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("rr%0d_ready", n), 32'(bus.req_ready), 32'(1 << (n % 4)));
            tick();
            tick();
            check($sformatf("rr%0d_valid", n), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("rr%0d_id", n),    32'(bus.rsp_id),    32'(n % 4));
            check($sformatf("rr%0d_code", n),  32'(bus.rsp_code),  32'(codes[n % 4]));
            tick();
        end

        // Backpressure in RESP: outputs stable, no new grant
        bus.rsp_ready = 1'b0;
        check("bp_grant", 32'(bus.req_ready), 32'h2);
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp%0d_valid", n), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d_id", n),    32'(bus.rsp_id),    32'd1);
            check($sformatf("bp%0d_code", n),  32'(bus.rsp_code),  32'h2);
            check($sformatf("bp%0d_ready", n), 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_next_grant",    32'(bus.req_ready), 32'h4);
        tick();
        // Operands change after handshake; result uses captured 9 vs 5
        set_ops(2, 32'd5, 32'd5);
        bus.req_valid = 4'b0000;
        tick();
        check("cap_valid", 32'(bus.rsp_valid), 32'd1);
        check("cap_id",    32'(bus.rsp_id),    32'd2);
        check("cap_code",  32'(bus.rsp_code),  32'h1);
        tick();
        check("cap_done", 32'(bus.rsp_valid), 32'd0);

        // Requester 3 withdraws while requester 1 is serviced
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(1, 32'd7, 32'd7);
        bus.req_valid = 4'b1010;
        #1;
        check("wd_grant1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0000;
        check("wd_exec_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("wd_rsp_id",   32'(bus.rsp_id),   32'd1);
        check("wd_rsp_code", 32'(bus.rsp_code), 32'h3);
        tick();
        for (int n = 0; n < 3; n++) begin
            check($sformatf("wd%0d_ready", n), 32'(bus.req_ready), 32'h0);
            check($sformatf("wd%0d_valid", n), 32'(bus.rsp_valid), 32'd0);
            tick();
        end

        // Reset wins over a same-cycle request
        bus.req_valid = 4'b0001;
        rst = 1'b1;
        #1;
        check("rp_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("rp_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // CMP_LAT=3: reset during EXEC discards the request and clears rr_ptr
        set_ops3(2, 32'd3, 32'd3);
        bus3.req_valid = 4'b0100;
        bus3.rsp_ready = 1'b1;
        #1;
        check("l3_grant2", 32'(bus3.req_ready), 32'h4);
        tick();
        bus3.req_valid = 4'b0000;
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("l3_flush%0d", n), 32'(bus3.rsp_valid), 32'd0);
            tick();
        end
        set_ops3(1, 32'd7, 32'd3);
        set_ops3(3, 32'd1, 32'd2);
        bus3.req_valid = 4'b1010;
        #1;
        check("l3_grant1", 32'(bus3.req_ready), 32'h2);
        tick();
        bus3.req_valid = 4'b0000;
        for (int n = 1; n < 4; n++) begin
            check($sformatf("l3_lat_edge%0d", n), 32'(bus3.rsp_valid), 32'd0);
            tick();
        end
        check("l3_valid", 32'(bus3.rsp_valid), 32'd1);
        check("l3_id",    32'(bus3.rsp_id),    32'd1);
        check("l3_code",  32'(bus3.rsp_code),  32'h1);
        tick();
        check("l3_done", 32'(bus3.rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
